// File: rtl/sr_dmem_ctrl_if.sv
// rtl/sr_dmem_ctrl_if.sv - core request / data-RAM bus bundle for sr_dmem_ctrl
//
// Purpose : groups the core-side load/store handshake and the RAM-side
//           word port of the data-memory sequencer into one bundle.
// Signals :
//   core side : req, we, sign, opByte, opHalf, opWord, addr[31:0],
//               wdata[31:0]  -> controller
//               rdata[31:0], ack, misalign  <- controller
//   RAM side  : memAddr[AW-1:0], memRe, memWe, memWData[31:0] <- controller
//               memRData[31:0] -> controller
// Modports: slave = the controller, master = its environment (core + RAM).

interface sr_dmem_ctrl_if #(
    parameter int AW = 10
);
    logic          req;
    logic          we;
    logic          sign;
    logic          opByte;
    logic          opHalf;
    logic          opWord;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ack;
    logic          misalign;
    logic [AW-1:0] memAddr;
    logic          memRe;
    logic          memWe;
    logic [31:0]   memWData;
    logic [31:0]   memRData;

    modport slave (
        input  req, we, sign, opByte, opHalf, opWord, addr, wdata, memRData,
        output rdata, ack, misalign, memAddr, memRe, memWe, memWData
    );

    modport master (
        output req, we, sign, opByte, opHalf, opWord, addr, wdata, memRData,
        input  rdata, ack, misalign, memAddr, memRe, memWe, memWData
    );
endinterface

// File: rtl/sr_dmem_ctrl.sv
// rtl/sr_dmem_ctrl.sv - multi-cycle load/store sequencer for a word-wide data RAM
//
// Purpose : executes byte/half/word loads and stores against a synchronous
//           single-port RAM without byte enables. Sub-word loads extract and
//           sign/zero-extend a lane; sub-word stores use read-modify-write.
// Ports   :
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous active-high reset
//   bus    - sr_dmem_ctrl_if.slave (core request/response + RAM port)
// Latency from the IDLE cycle that samples req (cycle 0) to ack:
//   load 2, word store 1, sub-word store 3, error 1.

module sr_dmem_ctrl #(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sr_dmem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LD_RD     = 3'd1,
        LD_DATA   = 3'd2,
        RMW_RD    = 3'd3,
        RMW_MERGE = 3'd4,
        ST_WR     = 3'd5,
        ERR       = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;

    // Request fields captured when IDLE accepts a request
    logic          r_byte;
    logic          r_half;
    logic          r_sign;
    logic [1:0]    r_lane;
    logic [15:0]   r_wdata;

    // Registered RAM port and held load result
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_re;
    logic          r_mem_we;
    logic [31:0]   r_mem_wdata;
    logic [31:0]   r_rdata;

    logic          w_accept;
    logic          w_onehot;
    logic          w_err;
    logic [7:0]    w_ld_byte;
    logic [15:0]   w_ld_half;
    logic [31:0]   w_ld_data;
    logic [31:0]   w_merged;
    logic          w_ack;
    logic          w_misalign;
    logic [31:0]   w_rdata;
    logic          w_unused_addr;

    // Only the word-address bits and the lane bits of addr matter here
    assign w_unused_addr = ^bus.addr[31:AW+2];

    assign w_accept = (r_state == IDLE) && bus.req;

    // Exactly one of the three op bits must be set
    assign w_onehot = (bus.opByte && !bus.opHalf && !bus.opWord) ||
                      (!bus.opByte && bus.opHalf && !bus.opWord) ||
                      (!bus.opByte && !bus.opHalf && bus.opWord);

    assign w_err = !w_onehot ||
                   (bus.opHalf && bus.addr[0]) ||
                   (bus.opWord && (bus.addr[1:0] != 2'b00));

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    if (w_err) begin
                        w_next = ERR;
                    end else if (!bus.we) begin
                        w_next = LD_RD;
                    end else if (bus.opWord) begin
                        w_next = ST_WR;
                    end else begin
                        w_next = RMW_RD;
                    end
                end
            end
            LD_RD:     w_next = LD_DATA;
            LD_DATA:   w_next = IDLE;
            RMW_RD:    w_next = RMW_MERGE;
            RMW_MERGE: w_next = ST_WR;
            ST_WR:     w_next = IDLE;
            ERR:       w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs derived from the current state
    // ---------------------------------------------------------------
    always_comb begin
        w_ack      = 1'b0;
        w_misalign = 1'b0;
        w_rdata    = r_rdata;
        case (r_state)
            LD_DATA: begin
                w_ack   = 1'b1;
                w_rdata = w_ld_data;
            end
            ST_WR: begin
                w_ack = 1'b1;
            end
            ERR: begin
                w_ack      = 1'b1;
                w_misalign = 1'b1;
                w_rdata    = 32'h0;
            end
            default: begin
                w_ack = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Load lane extraction from the RAM read word
    // ---------------------------------------------------------------
    always_comb begin
        w_ld_byte = 8'h00;
        case (r_lane)
            2'd0:    w_ld_byte = bus.memRData[7:0];
            2'd1:    w_ld_byte = bus.memRData[15:8];
            2'd2:    w_ld_byte = bus.memRData[23:16];
            default: w_ld_byte = bus.memRData[31:24];
        endcase
        w_ld_half = r_lane[1] ? bus.memRData[31:16] : bus.memRData[15:0];

        if (r_byte) begin
            w_ld_data = {{24{r_sign & w_ld_byte[7]}}, w_ld_byte};
        end else if (r_half) begin
            w_ld_data = {{16{r_sign & w_ld_half[15]}}, w_ld_half};
        end else begin
            w_ld_data = bus.memRData;
        end
    end

    // ---------------------------------------------------------------
    // Store merge: replace the addressed lane in the word just read
    // ---------------------------------------------------------------
    always_comb begin
        w_merged = bus.memRData;
        if (r_byte) begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_wdata;
        end else begin
            w_merged[15:0] = r_wdata;
        end
    end

    // ---------------------------------------------------------------
    // Datapath registers. memRe/memWe are registered from the next state
    // so they are asserted exactly in LD_RD/RMW_RD and ST_WR.
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_byte      <= 1'b0;
            r_half      <= 1'b0;
            r_sign      <= 1'b0;
            r_lane      <= 2'b00;
            r_wdata     <= 16'h0;
            r_mem_addr  <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 32'h0;
            r_rdata     <= 32'h0;
        end else begin
            r_mem_re <= (w_next == LD_RD) || (w_next == RMW_RD);
            r_mem_we <= (w_next == ST_WR);

            if (w_accept) begin
                r_byte     <= bus.opByte;
                r_half     <= bus.opHalf;
                r_sign     <= bus.sign;
                r_lane     <= bus.addr[1:0];
                r_wdata    <= bus.wdata[15:0];
                r_mem_addr <= bus.addr[AW+1:2];
                // A full-word store needs no read, so its data goes out now
                if (!w_err && bus.we && bus.opWord) begin
                    r_mem_wdata <= bus.wdata;
                end
            end

            if (r_state == RMW_MERGE) begin
                r_mem_wdata <= w_merged;
            end

            if (r_state == LD_DATA) begin
                r_rdata <= w_ld_data;
            end else if (r_state == ERR) begin
                r_rdata <= 32'h0;
            end
        end
    end

    assign bus.rdata    = w_rdata;
    assign bus.ack      = w_ack;
    assign bus.misalign = w_misalign;
    assign bus.memAddr  = r_mem_addr;
    assign bus.memRe    = r_mem_re;
    assign bus.memWe    = r_mem_we;
    assign bus.memWData = r_mem_wdata;

endmodule

// File: tb/tb_sr_dmem_ctrl.sv
// tb/tb_sr_dmem_ctrl.sv - scoreboard testbench for sr_dmem_ctrl

module tb_sr_dmem_ctrl;

    localparam int AW = 10;

    logic clk;
    logic rst;

    sr_dmem_ctrl_if #(.AW(AW)) bif ();

    sr_dmem_ctrl #(.AW(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model: read data appears the cycle after memRe
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bif.memWe) mem[bif.memAddr] <= bif.memWData;
        if (bif.memRe) bif.memRData <= mem[bif.memAddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-transaction RAM activity monitor, snapshotted at each ack
    int          re_cnt = 0, we_cnt = 0, re_cyc = 0, tot_we = 0;
    logic [31:0] wd_seen = 32'h0;
    int          s_re_cnt = 0, s_we_cnt = 0, s_re_cyc = 0;
    logic [31:0] s_wd = 32'h0;
    int          n_both = 0;

    always @(negedge clk) begin
        if (rst) begin
            re_cnt = 0;
            we_cnt = 0;
        end else begin
            if (bif.memRe && bif.memWe) n_both = n_both + 1;
            if (bif.memRe) begin
                if (re_cnt == 0) re_cyc = cyc;
                re_cnt = re_cnt + 1;
            end
            if (bif.memWe) begin
                we_cnt  = we_cnt + 1;
                tot_we  = tot_we + 1;
                wd_seen = bif.memWData;
            end
            if (bif.ack) begin
                s_re_cnt = re_cnt;
                s_we_cnt = we_cnt;
                s_re_cyc = re_cyc;
                s_wd     = wd_seen;
                re_cnt   = 0;
                we_cnt   = 0;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        chk_rd;
        logic        mis;
        int          lat;
        int          re;
        int          we;
        logic [31:0] mwd;
        logic [AW-1:0] maddr;
    } exp_t;

    exp_t sb[$];

    // Called at posedge+1; the current cycle is the IDLE sampling cycle
    task automatic send(input string name, input logic w, input logic s,
                        input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic chk_rd, input logic exp_mis, input int exp_lat,
                        input int exp_re, input int exp_we,
                        input logic [31:0] exp_mwd, input logic keep_req);
        exp_t e;
        exp_t g;
        int   issue;
        bit   got;
        e.name = name; e.rd = exp_rd; e.chk_rd = chk_rd; e.mis = exp_mis;
        e.lat = exp_lat; e.re = exp_re; e.we = exp_we; e.mwd = exp_mwd;
        e.maddr = a[AW+1:2];
        sb.push_back(e);
        bif.req = 1'b1; bif.we = w; bif.sign = s;
        bif.opByte = op[2]; bif.opHalf = op[1]; bif.opWord = op[0];
        bif.addr = a; bif.wdata = wd;
        issue = cyc;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bif.ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check({name, " ack_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end else begin
            g = sb.pop_front();
            check({g.name, " latency"}, cyc - issue, g.lat);
            check({g.name, " misalign"}, {31'd0, bif.misalign}, {31'd0, g.mis});
            if (g.chk_rd) check({g.name, " rdata"}, bif.rdata, g.rd);
            check({g.name, " memAddr"}, {{(32-AW){1'b0}}, bif.memAddr}, {{(32-AW){1'b0}}, g.maddr});
            check({g.name, " memRe_cnt"}, s_re_cnt, g.re);
            check({g.name, " memWe_cnt"}, s_we_cnt, g.we);
            if (g.re > 0) check({g.name, " memRe_cycle"}, s_re_cyc - issue, 1);
            if (g.we > 0) check({g.name, " memWData"}, s_wd, g.mwd);
        end
        @(posedge clk);
        #1;
        if (!keep_req) bif.req = 1'b0;
    endtask

    localparam logic [2:0] OP_B = 3'b100;
    localparam logic [2:0] OP_H = 3'b010;
    localparam logic [2:0] OP_W = 3'b001;

    int tot_we_before;

    initial begin
        rst = 1'b1;
        bif.req = 1'b0; bif.we = 1'b0; bif.sign = 1'b0;
        bif.opByte = 1'b0; bif.opHalf = 1'b0; bif.opWord = 1'b0;
        bif.addr = 32'h0; bif.wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", {31'd0, bif.ack}, 32'd0);
        check("reset misalign", {31'd0, bif.misalign}, 32'd0);
        check("reset rdata", bif.rdata, 32'd0);
        check("reset memRe_memWe", {30'd0, bif.memRe, bif.memWe}, 32'd0);
        check("reset memAddr", {{(32-AW){1'b0}}, bif.memAddr}, 32'd0);
        check("reset memWData", bif.memWData, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Byte loads
        send("SW_100", 1, 0, OP_W, 32'h100, 32'h80FF1234, 0, 0, 0, 1, 0, 1, 32'h80FF1234, 0);
        send("LB_103", 0, 1, OP_B, 32'h103, 0, 32'hFFFFFF80, 1, 0, 2, 1, 0, 0, 0);
        send("LBU_103", 0, 0, OP_B, 32'h103, 0, 32'h00000080, 1, 0, 2, 1, 0, 0, 0);
        send("LB_100", 0, 1, OP_B, 32'h100, 0, 32'h00000034, 1, 0, 2, 1, 0, 0, 0);

        // Half / word loads
        send("SW_0", 1, 0, OP_W, 32'h0, 32'h80010203, 0, 0, 0, 1, 0, 1, 32'h80010203, 0);
        send("LH_2", 0, 1, OP_H, 32'h2, 0, 32'hFFFF8001, 1, 0, 2, 1, 0, 0, 0);
        send("LHU_2", 0, 0, OP_H, 32'h2, 0, 32'h00008001, 1, 0, 2, 1, 0, 0, 0);
        send("LH_0", 0, 1, OP_H, 32'h0, 0, 32'h00000203, 1, 0, 2, 1, 0, 0, 0);
        send("LW_0", 0, 0, OP_W, 32'h0, 0, 32'h80010203, 1, 0, 2, 1, 0, 0, 0);

        // Sub-word stores (read-modify-write)
        send("SW_4", 1, 0, OP_W, 32'h4, 32'h11223344, 0, 0, 0, 1, 0, 1, 32'h11223344, 0);
        send("SB_5", 1, 0, OP_B, 32'h5, 32'h000000AB, 0, 0, 0, 3, 1, 1, 32'h1122AB44, 0);
        send("SW_4b", 1, 0, OP_W, 32'h4, 32'h11223344, 0, 0, 0, 1, 0, 1, 32'h11223344, 0);
        send("SH_6", 1, 0, OP_H, 32'h6, 32'h0000BEEF, 0, 0, 0, 3, 1, 1, 32'hBEEF3344, 0);
        send("LW_4", 0, 0, OP_W, 32'h4, 0, 32'hBEEF3344, 1, 0, 2, 1, 0, 0, 0);

        // Error responses
        send("SW_6_err", 1, 0, OP_W, 32'h6, 32'h12345678, 32'h0, 1, 1, 1, 0, 0, 0, 0);
        send("op011_err", 0, 0, 3'b011, 32'h8, 0, 32'h0, 1, 1, 1, 0, 0, 0, 0);
        send("LH_1_err", 0, 1, OP_H, 32'h1, 0, 32'h0, 1, 1, 1, 0, 0, 0, 0);

        // Back-to-back with req held high
        send("SW_10_b2b", 1, 0, OP_W, 32'h10, 32'hCAFEF00D, 0, 0, 0, 1, 0, 1, 32'hCAFEF00D, 1);
        send("LW_10_b2b", 0, 0, OP_W, 32'h10, 0, 32'hCAFEF00D, 1, 0, 2, 1, 0, 0, 0);

        // Reset during RMW_MERGE of a byte store
        tot_we_before = tot_we;
        bif.req = 1'b1; bif.we = 1'b1; bif.sign = 1'b0;
        bif.opByte = 1'b1; bif.opHalf = 1'b0; bif.opWord = 1'b0;
        bif.addr = 32'h10; bif.wdata = 32'h00000055;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bif.req = 1'b0;
        #1;
        check("abort ack", {31'd0, bif.ack}, 32'd0);
        check("abort misalign", {31'd0, bif.misalign}, 32'd0);
        check("abort memRe_memWe", {30'd0, bif.memRe, bif.memWe}, 32'd0);
        check("abort memAddr", {{(32-AW){1'b0}}, bif.memAddr}, 32'd0);
        check("abort memWData", bif.memWData, 32'd0);
        check("abort rdata", bif.rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort no memWe", tot_we, tot_we_before);
        send("LW_10_after", 0, 0, OP_W, 32'h10, 0, 32'hCAFEF00D, 1, 0, 2, 1, 0, 0, 0);

        check("memRe_memWe_overlap", n_both, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 1, 0);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/sr_dmem_ctrl.md
Name: sr_dmem_ctrl

Overview:
Multi-cycle data-memory access sequencer between the CPU datapath and a word-wide, synchronous single-port data RAM with no byte enables. It executes the load/store requests decoded by the control unit (dmWe, dmSign, dmOpByte/Half/Word). Sub-word loads use lane extraction with sign or zero extension. Sub-word stores use read-modify-write. The core stalls while req is high and ack is low.

Parameters:
AW, 10, word-address width of the data RAM (RAM holds 2^AW 32-bit words)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  access request; held with all request fields stable until ack
we  in  1  1 = store, 0 = load (from dmWe)
sign  in  1  signed load (from dmSign); ignored for stores
opByte  in  1  byte access
opHalf  in  1  halfword access
opWord  in  1  word access
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rd2); low byte/half used for SB/SH
rdata  out  32  load result, valid while ack=1, held until the next ack
ack  out  1  one-cycle completion pulse
misalign  out  1  error flag, valid with ack
memAddr  out  AW  RAM word address = addr[AW+1:2], registered
memRe  out  1  RAM read enable, registered; data appears on memRData the following cycle
memWe  out  1  RAM write enable, registered, one cycle per store
memWData  out  32  RAM write data, registered
memRData  in  32  RAM read data

Behaviour:
- Reset: state IDLE; rdata, ack, misalign, memAddr, memRe, memWe and memWData all 0. A reset mid-operation aborts immediately, and memWe drops asynchronously.
- FSM states: IDLE, LD_RD, LD_DATA, RMW_RD, RMW_MERGE, ST_WR, ERR.
- IDLE samples req each cycle. With req=1, the op, sign, addr lane and wdata are latched, and the next state is chosen in this order:
  - error (op bits not one-hot, half with addr[0]=1, or word with addr[1:0]≠0) → ERR
  - load → LD_RD
  - word store → ST_WR
  - byte/half store → RMW_RD
- LD_RD: memRe=1. Next state LD_DATA.
- LD_DATA: rdata is extracted from memRData, ack=1. Next state IDLE.
- Load extraction:
  - Byte: lane addr[1:0], bits [8k+7:8k].
  - Half: addr[1] selects [15:0] or [31:16].
  - Sub-word results are sign-extended when sign=1, otherwise zero-extended.
  - Word: passed through unchanged.
- RMW_RD: memRe=1. Next state RMW_MERGE.
- RMW_MERGE: memWData = memRData with the selected byte/half lane replaced by wdata[7:0] or wdata[15:0]. Next state ST_WR.
- ST_WR: memWe=1, memWData holds the merged or full word, ack=1. Next state IDLE.
- ERR: ack=1, misalign=1, rdata=0, no memRe/memWe. Next state IDLE.
- Latency from the req-sampling cycle in IDLE (cycle 0) to ack:
  - load: ack in cycle 2
  - word store: ack in cycle 1
  - sub-word store: ack in cycle 3
  - error: ack in cycle 1
- memRe and memWe are never high in the same cycle. memWe is high for exactly one cycle per store and never for a load or an error.
- req is not sampled outside IDLE. After ack, the FSM returns to IDLE, and the core has updated req at that edge, so back-to-back requests issue with no gap and no double execution.
- req dropping before ack (protocol violation): the access still completes and acks.
- memAddr is held stable from the request through ack.

Test Plan:
- LB at addr 0x103, RAM word 0x80FF1234 → ack in cycle 2, rdata=0xFFFFFF80. Same access as LBU → rdata=0x00000080.
- LH at addr 0x2, RAM word 0x80010203 → rdata=0xFFFF8001. LHU → 0x00008001. LW at 0x0 → 0x80010203.
- SB addr 0x5, wdata 0x000000AB, RAM word[1]=0x11223344 → memRe in cycle 1, memWe for exactly one cycle in cycle 3, memAddr=1, memWData=0x1122AB44, ack in cycle 3. SH addr 0x6 wdata 0xBEEF → memWData=0xBEEF3344.
- SW addr 0x6 → ack in cycle 1 with misalign=1, no memRe/memWe. Op bits 3'b011 → same error response.
- Back-to-back SW 0x10 then LW 0x10 with req held high → second request sampled the cycle after the first ack, and the load returns the stored value.
- rst asserted during RMW_MERGE → memWe never pulses, all outputs 0 immediately, state IDLE. After release, a fresh LW completes normally.
